// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared CPU types: ALU operation encoding, datapath width and the request
//   bundle that alu_arbiter multiplexes onto its single alu instance.
//   Encodings above ALU_AND are unused; the alu returns 0 for them.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } t_alu_op;

  // Upper bound on alu_arbiter's NUM_REQ parameter.
  localparam int ALU_ARB_MAX_REQ = 8;

  typedef struct packed {
    t_alu_op         op;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
  } t_alu_req;

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   Purely combinational integer ALU.
//   Ports:
//     op      in  ALU_OP_W  operation (t_alu_op encoding; unused codes give 0)
//     in1     in  DATA_W    operand A
//     in2     in  DATA_W    operand B (low bits are the shift amount)
//     alu_out out DATA_W    result
// -----------------------------------------------------------------------------
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   in1,
  input  logic [DATA_W-1:0]   in2,
  output logic [DATA_W-1:0]   alu_out
);

  localparam int SH_W = $clog2(DATA_W);

  logic signed [DATA_W-1:0] in1_s;
  logic signed [DATA_W-1:0] in2_s;
  logic        [SH_W-1:0]   shamt;

  assign in1_s = in1;
  assign in2_s = in2;
  assign shamt = in2[SH_W-1:0];

  always_comb begin
    alu_out = '0;
    case (op)
      ALU_ADD:  alu_out = in1 + in2;
      ALU_SUB:  alu_out = in1 - in2;
      ALU_SLL:  alu_out = in1 << shamt;
      ALU_SLT:  alu_out = {{(DATA_W-1){1'b0}}, (in1_s < in2_s)};
      ALU_SLTU: alu_out = {{(DATA_W-1){1'b0}}, (in1 < in2)};
      ALU_XOR:  alu_out = in1 ^ in2;
      ALU_SRL:  alu_out = in1 >> shamt;
      // in1_s is signed, so >>> replicates the sign bit.
      ALU_SRA:  alu_out = in1_s >>> shamt;
      ALU_OR:   alu_out = in1 | in2;
      ALU_AND:  alu_out = in1 & in2;
      default:  alu_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one alu between NUM_REQ requesters. Round-robin arbitration, at
//   most one accept per cycle, result registered with the owner's ID and
//   returned over a valid/ready port. Full one-op-per-cycle throughput while
//   rsp_ready is high (the slot drains and reloads on the same edge).
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     req_valid[NUM_REQ]    requester i presents an operation
//     req_ready[NUM_REQ]    requester i is accepted this cycle (one-hot/zero)
//     req_op   NUM_REQ x ALU_OP_W, flattened (requester i at [i*ALU_OP_W +:])
//     req_in1  NUM_REQ x 32, flattened
//     req_in2  NUM_REQ x 32, flattened
//     rsp_valid/rsp_ready   response handshake
//     rsp_id   ID_W         owner of rsp_data
//     rsp_data 32           registered alu result
//
//   Optional feature, macro ALU_ARB_STATS_EN:
//     stats_clr in  1              synchronous clear of all grant counters
//     grant_cnt out NUM_REQ x 16   saturating per-requester accept counters
// -----------------------------------------------------------------------------
module alu_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ALU_OP_W-1:0] req_op,
  input  logic [NUM_REQ*XLEN-1:0]     req_in1,
  input  logic [NUM_REQ*XLEN-1:0]     req_in2,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [XLEN-1:0]             rsp_data
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                        stats_clr,
  output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

  // Control state
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q,    rsp_id_d;
  logic [ID_W-1:0] rr_ptr_q,    rr_ptr_d;
  // Data state
  logic [XLEN-1:0] rsp_data_q,  rsp_data_d;

  logic            slot_free;
  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic            accept;
  logic [ID_W:0]   cand_w;
  logic [ID_W:0]   nxt_w;

  t_alu_req        req_vec [NUM_REQ];
  t_alu_req        sel_req;
  logic [XLEN-1:0] alu_out;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_vec
    assign req_vec[g].op  = t_alu_op'(req_op[g*ALU_OP_W +: ALU_OP_W]);
    assign req_vec[g].in1 = req_in1[g*XLEN +: XLEN];
    assign req_vec[g].in2 = req_in2[g*XLEN +: XLEN];
  end

  // The slot can take a new result if it is empty or being drained right now.
  assign slot_free = !rsp_valid_q || rsp_ready;

  // Round-robin search: candidate k is (rr_ptr + k) mod NUM_REQ, computed one
  // bit wider so the wrap is a single conditional subtract.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand_w    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_w = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_w >= (ID_W+1)'(NUM_REQ)) begin
        cand_w = cand_w - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_any && req_valid[cand_w[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand_w[ID_W-1:0];
      end
    end
  end

  assign accept = grant_any && slot_free;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // ---- stage boundary: request mux -> alu -> result register D-input ----
  assign sel_req = req_vec[grant_id];

  alu #(
    .DATA_W (XLEN)
  ) u_alu (
    .op      (sel_req.op),
    .in1     (sel_req.in1),
    .in2     (sel_req.in2),
    .alu_out (alu_out)
  );

  always_comb begin
    nxt_w = {1'b0, grant_id} + (ID_W+1)'(1);
    if (nxt_w >= (ID_W+1)'(NUM_REQ)) begin
      nxt_w = '0;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      // A same-cycle drain and accept simply reloads the slot.
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_id;
      rsp_data_d  = alu_out;
      rr_ptr_d    = nxt_w[ID_W-1:0];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // ---- stage boundary: response register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Clear has priority over a same-cycle increment.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (req_valid[i] && req_ready[i]) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule
